truth_table_checker: RTL and testbench

- Sequential stimulus and check stage that sits directly in front of, and behind, a small combinational gate network.
- Drives every N_IN-bit input vector onto the network in ascending order and waits a programmable settle time.
- Samples the network's single output and compares it against a parameterised expected truth table.
- Reports pass/fail, error count and first failing vector. It replaces hand-written per-vector stimulus with a reusable clocked block.

---
 rtl/tt_pkg.sv | 19 +
 rtl/settle_timer.sv | 27 ++
 rtl/truth_table_checker.sv | 109 ++++++++++
 tb/tb_truth_table_checker.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_t;

    // Number of input vectors for a network with n_in inputs.
    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

    // out = !B & C with vector index {A,B,C}: vectors 1 and 5 are high.
    localparam logic [7:0] DEFAULT_EXP_TABLE = 8'b0010_0010;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: clear/enable controlled, flags the last hold cycle of a vector.
module settle_timer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == 4'(SETTLE_CYC - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors of a small combinational network and checks its output
// against an expected truth table, reporting error count and first failing vector.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                          N_IN       = 3,
    parameter int                          SETTLE_CYC = 1,
    parameter logic [(1 << N_IN)-1:0]      EXP_TABLE  = DEFAULT_EXP_TABLE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam int N_VEC = n_vec(N_IN);

    tt_state_t     state, state_next;
    logic          timer_clear, timer_en, timer_tc;
    logic          sweep_start, sample, last_vec, mismatch;
    logic [N_IN:0] err_next;

    settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        sweep_start = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sweep_start = 1'b1;
                    timer_clear = 1'b1;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (timer_tc) state_next = SAMPLE;
            end
            SAMPLE: begin
                sample      = 1'b1;
                timer_clear = 1'b1;
                state_next  = last_vec ? DONE : SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign last_vec = (vec_out == N_IN'(N_VEC - 1));
    assign mismatch = (dut_in != EXP_TABLE[vec_out]);
    assign err_next = err_count + (N_IN + 1)'(mismatch);

    // Result registers; dut_in only reaches them through the SAMPLE qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (sweep_start) begin
            vec_out          <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (sample) begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= vec_out;
            end
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == '0);
            end else begin
                vec_out <= vec_out + N_IN'(1);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised sweep bench: a table-driven network model feeds two checker instances
// (settle 1 and settle 3); results are predicted by comparing whole truth tables.
module tb_truth_table_checker;

    localparam logic [7:0] CORRECT = 8'b0010_0010;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_req;
    int         sel;
    logic [7:0] net_a, net_b;

    logic       start_a, start_b, dut_in_a, dut_in_b;
    logic [2:0] vec_a, vec_b, ffi_a, ffi_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
    logic [3:0] err_a, err_b;

    logic [2:0] o_vec, o_ffi;
    logic       o_busy, o_done, o_pass, o_ffv;
    logic [3:0] o_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start_a  = start_req && (sel == 0);
    assign start_b  = start_req && (sel == 1);
    assign dut_in_a = net_a[vec_a];
    assign dut_in_b = net_b[vec_b];

    truth_table_checker dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_in(dut_in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
    );

    truth_table_checker #(.SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_in(dut_in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
    );

    always_comb begin
        if (sel == 0) begin
            o_vec = vec_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            o_err = err_a; o_ffv = ffv_a; o_ffi = ffi_a;
        end else begin
            o_vec = vec_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            o_err = err_b; o_ffv = ffv_b; o_ffi = ffi_b;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full sweep on the selected instance; repulse_at >= 0 raises start again mid-sweep.
    task automatic run_sweep(input int s_sel, input logic [7:0] net, input int repulse_at);
        int         s, n_cyc, exp_err;
        logic       exp_ffv;
        logic [2:0] exp_ffi;
        s     = (s_sel == 1) ? 3 : 1;
        n_cyc = 8 * (s + 1);
        sel   = s_sel;
        if (s_sel == 1) net_b = net; else net_a = net;

        exp_err = 0; exp_ffv = 1'b0; exp_ffi = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (net[i] != CORRECT[i]) begin
                exp_err++;
                exp_ffv = 1'b1;
                exp_ffi = 3'(i);
            end
        end

        @(negedge clk); start_req = 1'b1;
        @(posedge clk); #1; start_req = 1'b0;
        for (int k = 0; k <= n_cyc; k++) begin
            if (k > 0) begin
                @(posedge clk); #1; start_req = 1'b0;
            end
            if (k == repulse_at) start_req = 1'b1;
            if (k < n_cyc) begin
                check($sformatf("vec s%0d k%0d", s, k), o_vec, k / (s + 1));
                check($sformatf("busy s%0d k%0d", s, k), o_busy, 1);
                check($sformatf("done_early s%0d k%0d", s, k), o_done, 0);
            end else begin
                check("done", o_done, 1);
                check("busy_end", o_busy, 0);
                check("vec_end", o_vec, 7);
                check("pass", o_pass, (exp_err == 0) ? 1 : 0);
                check("err_count", o_err, exp_err);
                check("ff_valid", o_ffv, exp_ffv);
                check("ff_idx", o_ffi, exp_ffi);
            end
        end
        @(posedge clk); #1;
        check("done_hold", o_done, 1);
        check("err_hold", o_err, exp_err);
        check("vec_hold", o_vec, 7);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " vec"},  o_vec, 0);
        check({tag, " busy"}, o_busy, 0);
        check({tag, " done"}, o_done, 0);
        check({tag, " pass"}, o_pass, 0);
        check({tag, " err"},  o_err, 0);
        check({tag, " ffv"},  o_ffv, 0);
        check({tag, " ffi"},  o_ffi, 0);
    endtask

    initial begin
        rst = 1'b1; start_req = 1'b0; sel = 0;
        net_a = CORRECT; net_b = CORRECT;
        repeat (3) @(posedge clk);
        #1;
        sel = 0; #1; check_reset_state("rst_a");
        sel = 1; #1; check_reset_state("rst_b");
        rst = 1'b0;

        run_sweep(0, CORRECT, -1);
        run_sweep(0, 8'h00, -1);
        run_sweep(0, ~CORRECT, -1);
        run_sweep(1, CORRECT, -1);
        run_sweep(0, CORRECT, 5);
        run_sweep(0, CORRECT, -1);

        // Reset in the middle of a faulty sweep discards the partial result.
        sel = 0; net_a = 8'hFF;
        @(negedge clk); start_req = 1'b1;
        @(posedge clk); #1; start_req = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_reset_state("mid_rst");
        run_sweep(0, 8'h20, -1);

        for (int i = 0; i < 6; i++) run_sweep(0, 8'($urandom), -1);
        for (int i = 0; i < 2; i++) run_sweep(1, 8'($urandom), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
